// File: rtl/edge_detector_pkg.sv
// Shared constants for the multi-channel edge detector: per-channel mode
// encoding and its field width within the packed i_mode bus.
package edge_detector_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
  localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser chain, optional persistence filter, registered
// edge pulses and sticky pending/overrun flags.
module edge_channel
  import edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int CNT_W         = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sig,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_clear,
  output logic              o_level,
  output logic              o_rise,
  output logic              o_fall,
  output logic              o_pending,
  output logic              o_overrun
);

  localparam logic [CNT_W:0] LP_FILTER = (CNT_W + 1)'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  logic                   w_level;
  logic                   r_level_d;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_pending;
  logic                   r_overrun;
  logic                   w_rise_en;
  logic                   w_fall_en;
  logic                   w_evt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  generate
    if (LP_FILTER != '0) begin : g_filter
      localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(LP_FILTER - 1'b1);

      logic [CNT_W-1:0] r_cnt;
      logic             r_level;

      // Counter tracks how long the synced value has disagreed with the level.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (w_synced == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          r_level <= w_synced;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_level = r_level;
    end else begin : g_bypass
      assign w_level = w_synced;
    end
  endgenerate

  assign w_rise_en = (i_mode == MODE_RISE) || (i_mode == MODE_BOTH);
  assign w_fall_en = (i_mode == MODE_FALL) || (i_mode == MODE_BOTH);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_rise    <= w_level & ~r_level_d & w_rise_en;
      r_fall    <= ~w_level & r_level_d & w_fall_en;
    end
  end

  assign w_evt = r_rise | r_fall;

  // An edge coinciding with a clear still sets pending so it is not lost.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_evt) begin
      r_pending <= 1'b1;
      if (i_clear)        r_overrun <= 1'b0;
      else if (r_pending) r_overrun <= 1'b1;
    end else if (i_clear) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign o_level   = w_level;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: replicates edge_channel per input and
// combines the pending flags into a registered interrupt.
module edge_detector_mc
  import edge_detector_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int CNT_W         = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [CHANNELS-1:0]          i_sig,
  input  logic [MODE_W*CHANNELS-1:0]   i_mode,
  input  logic [CHANNELS-1:0]          i_clear,
  output logic [CHANNELS-1:0]          o_level,
  output logic [CHANNELS-1:0]          o_rise,
  output logic [CHANNELS-1:0]          o_fall,
  output logic [CHANNELS-1:0]          o_pending,
  output logic [CHANNELS-1:0]          o_overrun,
  output logic                         o_irq
);

  logic [CHANNELS-1:0] w_pending;
  logic                r_irq;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      edge_channel #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .CNT_W         (CNT_W)
      ) u_ch (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_sig     (i_sig[gi]),
        .i_mode    (i_mode[gi*MODE_W +: MODE_W]),
        .i_clear   (i_clear[gi]),
        .o_level   (o_level[gi]),
        .o_rise    (o_rise[gi]),
        .o_fall    (o_fall[gi]),
        .o_pending (w_pending[gi]),
        .o_overrun (o_overrun[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_irq <= 1'b0;
    else          r_irq <= |w_pending;
  end

  assign o_pending = w_pending;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_edge_detector_mc.sv
// Bench for edge_detector_mc (4 channels, 2 sync stages, filter of 3):
// directed scenarios followed by random traffic, checked via a scoreboard.
module tb_edge_detector_mc;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int F  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] sig;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clear;
  logic [CH-1:0] o_level, o_rise, o_fall, o_pending, o_overrun;
  logic          o_irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] pend;
    logic [CH-1:0] ovr;
    logic          irq;
  } exp_t;

  exp_t sb[$];

  edge_detector_mc #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (SS),
    .FILTER_CYCLES (F),
    .CNT_W         (CW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sig     (sig),
    .i_mode    (mode),
    .i_clear   (clear),
    .o_level   (o_level),
    .o_rise    (o_rise),
    .o_fall    (o_fall),
    .o_pending (o_pending),
    .o_overrun (o_overrun),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: the synced value is the input seen SS edges ago; the
  // level adopts the synced value once the last F synced samples all agree
  // on a value different from it; pulses follow level changes by one edge.
  bit dl [CH][SS];
  bit win[CH][F];
  bit m_lvl[CH], m_lvl_d[CH], m_rise[CH], m_fall[CH], m_pend[CH], m_ovr[CH];
  bit m_irq;

  always @(posedge clk) begin : model
    exp_t e;
    bit s, same, any_pend, n_rise, n_fall;
    logic [1:0] md;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < SS; k++) dl[c][k] = 1'b0;
        for (int k = 0; k < F; k++) win[c][k] = 1'b0;
        m_lvl[c] = 0; m_lvl_d[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
        m_pend[c] = 0; m_ovr[c] = 0;
      end
      m_irq = 0;
    end else begin
      any_pend = 0;
      for (int c = 0; c < CH; c++) any_pend |= m_pend[c];
      for (int c = 0; c < CH; c++) begin
        md = mode[2*c +: 2];
        s = dl[c][SS-1];
        n_rise = m_lvl[c] && !m_lvl_d[c] && (md == 2'b01 || md == 2'b11);
        n_fall = !m_lvl[c] && m_lvl_d[c] && (md == 2'b10 || md == 2'b11);
        if (m_rise[c] || m_fall[c]) begin
          if (clear[c]) m_ovr[c] = 0;
          else if (m_pend[c]) m_ovr[c] = 1;
          m_pend[c] = 1;
        end else if (clear[c]) begin
          m_pend[c] = 0;
          m_ovr[c]  = 0;
        end
        m_rise[c]  = n_rise;
        m_fall[c]  = n_fall;
        m_lvl_d[c] = m_lvl[c];
        for (int k = F - 1; k > 0; k--) win[c][k] = win[c][k-1];
        win[c][0] = s;
        same = 1;
        for (int k = 0; k < F; k++) if (win[c][k] != s) same = 0;
        if (same) m_lvl[c] = s;
        for (int k = SS - 1; k > 0; k--) dl[c][k] = dl[c][k-1];
        dl[c][0] = sig[c];
      end
      m_irq = any_pend;
    end
    for (int c = 0; c < CH; c++) begin
      e.level[c] = m_lvl[c];
      e.rise[c]  = m_rise[c];
      e.fall[c]  = m_fall[c];
      e.pend[c]  = m_pend[c];
      e.ovr[c]   = m_ovr[c];
    end
    e.irq = m_irq;
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_entry_available", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("level",   32'(o_level),   32'(e.level));
      chk("rise",    32'(o_rise),    32'(e.rise));
      chk("fall",    32'(o_fall),    32'(e.fall));
      chk("pending", 32'(o_pending), 32'(e.pend));
      chk("overrun", 32'(o_overrun), 32'(e.ovr));
      chk("irq",     32'(o_irq),     32'(e.irq));
    end
  end

  initial begin
    rst_n = 1'b0;
    sig   = 4'hF;
    mode  = 8'hFF;
    clear = 4'h0;

    // Input high through reset: rise reported 6 edges after release
    tick(5);
    chk("t1_reset_rise", 32'(o_rise), 32'h0);
    chk("t1_reset_pend", 32'(o_pending), 32'h0);
    rst_n = 1'b1;
    tick(5);
    chk("t1_rise_early", 32'(o_rise), 32'h0);
    tick(1);
    chk("t1_rise_edge6", 32'(o_rise), 32'hF);
    tick(1);
    chk("t1_rise_once", 32'(o_rise), 32'h0);
    chk("t1_pending", 32'(o_pending), 32'hF);
    chk("t1_irq_lag", 32'(o_irq), 32'h0);
    tick(1);
    chk("t1_irq", 32'(o_irq), 32'h1);

    // Glitch rejection and 3-cycle acceptance on ch0
    sig = 4'h0;
    tick(12);
    clear = 4'hF; tick(1); clear = 4'h0; tick(2);
    sig[0] = 1'b1; tick(2); sig[0] = 1'b0; tick(12);
    chk("t2_glitch_pend", 32'(o_pending[0]), 32'h0);
    sig[0] = 1'b1; tick(3); sig[0] = 1'b0; tick(12);
    chk("t2_accept_pend", 32'(o_pending[0]), 32'h1);

    // Rising-only mode on ch1, then off
    clear = 4'hF; tick(1); clear = 4'h0;
    mode[3:2] = 2'b01;
    sig[1] = 1'b1; tick(10); sig[1] = 1'b0; tick(10);
    chk("t3_rise_pend", 32'(o_pending[1]), 32'h1);
    chk("t3_no_fall_ovr", 32'(o_overrun[1]), 32'h0);
    mode[3:2] = 2'b00;
    clear[1] = 1'b1; tick(1); clear[1] = 1'b0;
    sig[1] = 1'b1; tick(10); sig[1] = 1'b0; tick(10);
    chk("t3_off_pend", 32'(o_pending[1]), 32'h0);

    // Overrun on ch2 with two rising edges, then clear
    mode = 8'hFF;
    mode[5:4] = 2'b01;
    clear = 4'hF; tick(1); clear = 4'h0; tick(2);
    sig[2] = 1'b1; tick(10);
    chk("t4_pend_first", 32'(o_pending[2]), 32'h1);
    chk("t4_ovr_first", 32'(o_overrun[2]), 32'h0);
    sig[2] = 1'b0; tick(10);
    sig[2] = 1'b1; tick(10);
    chk("t4_ovr_second", 32'(o_overrun[2]), 32'h1);
    clear[2] = 1'b1; tick(1); clear[2] = 1'b0;
    chk("t4_clr_pend", 32'(o_pending[2]), 32'h0);
    chk("t4_clr_ovr", 32'(o_overrun[2]), 32'h0);
    chk("t4_irq_lag", 32'(o_irq), 32'h1);
    tick(1);
    chk("t4_irq_clr", 32'(o_irq), 32'h0);

    // Clear coinciding with a fall pulse on ch3
    mode = 8'hFF;
    sig[3] = 1'b1; tick(10);
    sig[3] = 1'b0; tick(10);
    sig[3] = 1'b1; tick(10);
    chk("t5_ovr_before", 32'(o_overrun[3]), 32'h1);
    sig[3] = 1'b0; tick(6);
    chk("t5_fall_edge6", 32'(o_fall[3]), 32'h1);
    clear[3] = 1'b1; tick(1); clear[3] = 1'b0;
    chk("t5_pend_kept", 32'(o_pending[3]), 32'h1);
    chk("t5_ovr_clr", 32'(o_overrun[3]), 32'h0);

    // Reset while ch0 filter count is 2
    sig = 4'h0; tick(12);
    sig[0] = 1'b1; tick(4);
    rst_n = 1'b0; tick(1);
    chk("t6_rst_level", 32'(o_level), 32'h0);
    chk("t6_rst_rise", 32'(o_rise), 32'h0);
    chk("t6_rst_pend", 32'(o_pending), 32'h0);
    chk("t6_rst_irq", 32'(o_irq), 32'h0);
    rst_n = 1'b1;
    tick(5);
    chk("t6_rise_early", 32'(o_rise[0]), 32'h0);
    tick(1);
    chk("t6_rise_edge6", 32'(o_rise[0]), 32'h1);

    // Random traffic, including fast toggling and occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(5) == 0) sig[c] = ~sig[c];
      if ($urandom_range(49) == 0) mode = 8'($urandom);
      clear = 4'h0;
      for (int c = 0; c < CH; c++) if ($urandom_range(19) == 0) clear[c] = 1'b1;
      rst_n = ($urandom_range(499) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    clear = 4'h0;
    tick(3);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_detector_mc.md
Name: edge_detector_mc

Overview:
Multi-channel, parametrised edge detector for slow or asynchronous signals (SPI SCLK, CS, board-level strobes) in the i_clk domain.
- Per channel: synchroniser chain, optional glitch filter, selectable edge mode.
- Registered one-cycle edge pulses, sticky pending/overrun flags with clear, and a combined interrupt.
- Sits between external pins or slow clocks and controller FSMs such as the SPI controller.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER_CYCLES, 0, consecutive synced cycles a new level must hold before it is accepted; 0 = filter bypassed
CNT_W, 4, filter counter width; must satisfy 2^CNT_W > FILTER_CYCLES

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  synchronous active-low reset
i_sig  input  CHANNELS  raw, possibly asynchronous, input signals
i_mode  input  2*CHANNELS  per-channel mode, ch c at [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both
i_clear  input  CHANNELS  per-channel clear of pending/overrun (level, one-cycle pulse expected)
o_level  output  CHANNELS  synchronised, filtered level
o_rise  output  CHANNELS  one-cycle rising-edge pulse (masked by mode)
o_fall  output  CHANNELS  one-cycle falling-edge pulse (masked by mode)
o_pending  output  CHANNELS  sticky: enabled edge seen since last clear
o_overrun  output  CHANNELS  sticky: enabled edge seen while pending already set
o_irq  output  1  registered OR of o_pending

Behaviour:
- Reset (i_rst_n=0 at a clock edge): sync chain, filtered level, delayed level, filter counter, o_rise, o_fall, o_pending, o_overrun and o_irq all go to 0. o_level=0.
- Reset mid-operation: in-flight filter counts are discarded. No pulse is emitted for an edge still inside the pipeline.
- Filtered level is 0 after reset. An input already high at release is reported as a rising edge after normal latency.
- Sync: s = output of the last of SYNC_STAGES flops.
- Filter with FILTER_CYCLES=F>0:
  - Counter clears whenever s == level.
  - While s != level, counter increments each cycle.
  - On the cycle the counter would reach F, level <= s and the counter clears.
  - A synced excursion shorter than F cycles is rejected: no level change, no pulse.
- Filter with F=0: level = s directly.
- Edge detect: level_d is level delayed one cycle.
  - Raw rise = level & ~level_d. Raw fall = ~level & level_d.
  - o_rise = registered (raw rise & mode[0]). o_fall = registered (raw fall & mode[1]).
  - Each pulse is exactly one cycle.
- Latency: first i_clk edge sampling the new input value to the pulse-high edge = SYNC_STAGES + F + 1 edges. For defaults this is 3 edges.
- o_level is independent of mode.
- Mode changes take effect on the next edge. A pulse already registered is not retracted.
- Pending/overrun per channel, evaluated on the cycle o_rise|o_fall is high:
  - Edge with pending=0: pending <= 1.
  - Edge with pending=1 and no clear: overrun <= 1.
  - i_clear without edge: pending <= 0, overrun <= 0.
  - i_clear and edge in the same cycle: pending <= 1, overrun <= 0. Set wins; the event is not lost.
- o_irq is updated one cycle after o_pending.
- Minimum resolvable input period: 2*(F+1) synced cycles. Faster toggling is filtered or merged; no X or stuck state results.

Decomposition:
- Package edge_detector_pkg: mode constants MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH, and the 2-bit mode width.
- Sub-module edge_channel: one channel's sync, filter, detect and sticky logic.
  - Instantiated CHANNELS times via generate.
  - Top level slices i_mode and ORs pending into o_irq.

Test Plan (CHANNELS=4, SYNC_STAGES=2, FILTER_CYCLES=3, all modes 11 unless stated):
1. Hold i_rst_n=0 for 5 cycles with i_sig=4'hF → all outputs 0. Release → o_rise=4'hF for exactly one cycle, 6 edges after the first sampling edge. o_pending=4'hF. o_irq=1 one cycle later.
2. Glitch: ch0 high for 2 cycles → o_level[0] stays 0, no pulse. Then ch0 high for 3+ cycles → o_level[0]=1, o_rise[0] high one cycle, o_fall[0]=0.
3. Mode: ch1 mode=01, toggle 0→1→0 with 10-cycle gaps → one o_rise[1] pulse, zero o_fall[1] pulses, o_level[1] follows both transitions. Switch to mode=00 → no pulses and no pending.
4. Sticky/overrun: two rising edges on ch2 without clear → o_pending[2]=1 after the first, o_overrun[2]=1 after the second. i_clear[2]=1 for one cycle → both 0 on the next edge, o_irq=0 one cycle later.
5. Simultaneous: i_clear[3] asserted in the same cycle o_fall[3] is high, with pending[3]=1 → o_pending[3]=1, o_overrun[3]=0.
6. Reset mid-operation: assert i_rst_n=0 while the ch0 filter count is 2 → next edge all outputs 0. After release, with ch0 held high, the pulse appears only after the full 6-edge latency.
